// File: rtl/regfile_pkg.sv
// Shared sizing and types for the integer register file.
package regfile_pkg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    localparam logic [AW-1:0] ZERO_REG = 5'd31;

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot decoder; all outputs low when disabled.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic        i_en,
    input  reg_addr_t   i_idx,
    output logic [31:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = i_en;
    end

endmodule

// File: rtl/regfile_write_port.sv
// Register file write side: one-entry pending stage, one-hot commit into 31
// storage registers, and a hardwired-zero register 31 (XZR).
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = regfile_pkg::WIDTH,
    parameter int unsigned NREGS = regfile_pkg::NREGS,
    parameter int unsigned AW    = regfile_pkg::AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] regs [NREGS],
    output logic             pend_valid,
    output logic [AW-1:0]    pend_addr,
    output logic [WIDTH-1:0] pend_data,
    output logic [NREGS-1:0] wr_onehot
);

    logic             r_pend_valid;
    logic [AW-1:0]    r_pend_addr;
    logic [WIDTH-1:0] r_pend_data;
    logic [WIDTH-1:0] r_regs [NREGS-1];
    logic [NREGS-1:0] w_onehot;
    logic             w_accept;

    // XZR writes are dropped here so they never reach the decoder.
    assign w_accept = wr_en && (wr_addr != ZERO_REG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= w_accept;
            if (wr_en) begin
                r_pend_addr <= wr_addr;
                r_pend_data <= wr_data;
            end
        end
    end

    decoder5_32 u_dec (
        .i_en     (r_pend_valid),
        .i_idx    (r_pend_addr),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS - 1; i++) begin
                if (w_onehot[i]) begin
                    r_regs[i] <= r_pend_data;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREGS - 1; i++) begin
            regs[i] = r_regs[i];
        end
        regs[NREGS-1] = '0;
    end

    assign pend_valid = r_pend_valid;
    assign pend_addr  = r_pend_addr;
    assign pend_data  = r_pend_data;
    assign wr_onehot  = w_onehot;

endmodule
